// File: rtl/pulse_trigger_processor.sv
// Pops one trigger word per trigger, waits for every enabled channel to finish
// (or a timeout), then emits a readout record and keeps status counters.
module pulse_trigger_processor #(
    parameter int TIMEOUT_CYCLES = 4000,
    parameter int NUM_CHAN       = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                trig_fifo_valid,
    input  logic [127:0]        trig_fifo_data,
    output logic                trig_fifo_ready,
    input  logic [NUM_CHAN-1:0] chan_en,
    input  logic [NUM_CHAN-1:0] chan_done,
    input  logic                ro_fifo_ready,
    output logic                ro_fifo_valid,
    output logic [127:0]        ro_fifo_data,
    output logic [31:0]         trig_count,
    output logic [15:0]         timeout_count,
    output logic                busy,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_WAIT  = 3'b010,
        S_STORE = 3'b100
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam int REC_W = 70 + 2 * NUM_CHAN + 1;

    state_t              state_q, state_d;
    logic [69:0]         data_q, data_d;
    logic [NUM_CHAN-1:0] en_q, en_d;
    logic [NUM_CHAN-1:0] done_q, done_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                timeout_q, timeout_d;
    logic                ro_valid_q, ro_valid_d;
    logic [127:0]        ro_data_q, ro_data_d;
    logic [31:0]         trig_count_q, trig_count_d;
    logic [15:0]         timeout_count_q, timeout_count_d;
    logic [NUM_CHAN-1:0] done_next;

    logic unused_data_bits;
    assign unused_data_bits = ^trig_fifo_data[127:70];

    function automatic logic [127:0] make_record(input logic [69:0]         info,
                                                 input logic [NUM_CHAN-1:0] en,
                                                 input logic [NUM_CHAN-1:0] done,
                                                 input logic                to);
        make_record = {{(128 - REC_W){1'b0}}, to, en, done, info};
    endfunction

    always_comb begin
        state_d         = state_q;
        data_d          = data_q;
        en_d            = en_q;
        done_d          = done_q;
        timer_d         = timer_q;
        timeout_d       = timeout_q;
        ro_valid_d      = ro_valid_q;
        ro_data_d       = ro_data_q;
        trig_count_d    = trig_count_q;
        timeout_count_d = timeout_count_q;
        done_next       = done_q | (chan_done & en_q);

        case (state_q)
            S_IDLE: begin
                if (trig_fifo_valid) begin
                    data_d    = trig_fifo_data[69:0];
                    en_d      = chan_en;
                    done_d    = '0;
                    timer_d   = '0;
                    timeout_d = 1'b0;
                    // With no channels enabled there is nothing to wait for.
                    if (chan_en == '0) begin
                        state_d    = S_STORE;
                        ro_valid_d = 1'b1;
                        ro_data_d  = make_record(trig_fifo_data[69:0], chan_en, '0, 1'b0);
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                done_d = done_next;
                if (done_next == en_q) begin
                    state_d    = S_STORE;
                    ro_valid_d = 1'b1;
                    ro_data_d  = make_record(data_q, en_q, done_next, 1'b0);
                end else if (timer_q == TIMER_LAST) begin
                    state_d    = S_STORE;
                    timeout_d  = 1'b1;
                    ro_valid_d = 1'b1;
                    ro_data_d  = make_record(data_q, en_q, done_next, 1'b1);
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STORE: begin
                if (ro_fifo_ready) begin
                    state_d      = S_IDLE;
                    ro_valid_d   = 1'b0;
                    trig_count_d = trig_count_q + 32'd1;
                    if (timeout_q && (timeout_count_q != 16'hFFFF))
                        timeout_count_d = timeout_count_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            data_q          <= '0;
            en_q            <= '0;
            done_q          <= '0;
            timer_q         <= '0;
            timeout_q       <= 1'b0;
            ro_valid_q      <= 1'b0;
            ro_data_q       <= '0;
            trig_count_q    <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            data_q          <= data_d;
            en_q            <= en_d;
            done_q          <= done_d;
            timer_q         <= timer_d;
            timeout_q       <= timeout_d;
            ro_valid_q      <= ro_valid_d;
            ro_data_q       <= ro_data_d;
            trig_count_q    <= trig_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign trig_fifo_ready = trig_fifo_valid && (state_q == S_IDLE);
    assign ro_fifo_valid   = ro_valid_q;
    assign ro_fifo_data    = ro_data_q;
    assign trig_count      = trig_count_q;
    assign timeout_count   = timeout_count_q;
    assign busy            = (state_q != S_IDLE);
    assign state           = state_q;

endmodule
